// File: rtl/jt9346_pkg.sv
// jt9346_pkg: opcodes, ext sub-codes and FSM states shared by the controller and the EEPROM model
package jt9346_pkg;
  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_WRAL = 2'b01;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_EWEN = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_OP, S_ADDR, S_WDATA, S_RDATA, S_GAP, S_POLL, S_DONE
  } state_t;
  function automatic logic has_wdata(input logic [1:0] op, input logic [1:0] sub);
    return op == OP_WRITE || (op == OP_EXT && sub == EXT_WRAL);
  endfunction
  function automatic logic needs_poll(input logic [1:0] op, input logic [1:0] sub);
    return op == OP_WRITE || op == OP_ERASE ||
           (op == OP_EXT && (sub == EXT_WRAL || sub == EXT_ERAL));
  endfunction
endpackage

// File: rtl/jt9346_sclk_gen.sv
// jt9346_sclk_gen: serial clock divider; each bit is DIV clk low then DIV clk high
module jt9346_sclk_gen #(
  parameter int DIV = 4
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] r_cnt;
  logic r_sclk, w_end;
  assign w_end  = i_en && r_cnt == CW'(DIV - 1);
  assign o_rise = w_end && !r_sclk;
  assign o_fall = w_end && r_sclk;
  assign o_sclk = r_sclk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt  <= (i_en && !w_end) ? r_cnt + 1'b1 : '0;
      r_sclk <= i_en && (r_sclk ^ w_end);
    end
endmodule

// File: rtl/jt9346_ctrl.sv
// jt9346_ctrl: command-level controller for a 93C46-style serial EEPROM
module jt9346_ctrl
  import jt9346_pkg::*;
#(
  parameter int AW   = 6,
  parameter int DW   = 16,
  parameter int DIV  = 4,
  parameter int TOUT = 65535
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          sclk,
  output logic          sdi,
  output logic          scs,
  input  logic          sdo
);
  localparam int SW = 2 + AW + DW;
  localparam int BW = $clog2(AW + DW + 2);
  localparam int TW = $clog2(TOUT + 2 * DIV + 1);
  state_t r_st, w_nxt;
  logic [1:0] r_op, r_sub;
  logic [SW-1:0] r_sh;
  logic [DW-1:0] r_data;
  logic [BW-1:0] r_bit, w_lim;
  logic [TW-1:0] r_tmo;
  logic r_err, w_en, w_rise, w_fall, w_last, w_acc;
  assign w_en   = r_st inside {S_START, S_OP, S_ADDR, S_WDATA, S_RDATA};
  assign w_acc  = cmd_valid && r_st == S_IDLE;
  // RDATA carries one extra bit for the dummy 0 ahead of the data word
  assign w_lim  = r_st == S_OP ? BW'(1) : r_st == S_ADDR ? BW'(AW - 1) :
                  r_st == S_WDATA ? BW'(DW - 1) : r_st == S_RDATA ? BW'(DW) : '0;
  assign w_last = w_fall && r_bit == w_lim;
  assign rsp_data = r_data;
  assign rsp_err  = r_err;
  jt9346_sclk_gen #(.DIV(DIV)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_en(w_en), .o_sclk(sclk), .o_rise(w_rise), .o_fall(w_fall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_st <= S_IDLE;
    else r_st <= w_nxt;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_IDLE:  if (cmd_valid) w_nxt = S_START;
      S_START: if (w_last) w_nxt = S_OP;
      S_OP:    if (w_last) w_nxt = S_ADDR;
      S_ADDR:  if (w_last) w_nxt = has_wdata(r_op, r_sub) ? S_WDATA : r_op == OP_READ ? S_RDATA : S_GAP;
      S_WDATA: if (w_last) w_nxt = S_GAP;
      S_RDATA: if (w_last) w_nxt = S_GAP;
      S_GAP:   if (r_tmo == TW'(2 * DIV - 1)) w_nxt = needs_poll(r_op, r_sub) ? S_POLL : S_DONE;
      S_POLL:  if (sdo || r_tmo == TW'(TOUT - 1)) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = r_st == S_IDLE;
    rsp_valid = r_st == S_DONE;
    scs       = w_en || r_st == S_POLL;
    sdi       = r_st == S_START || (r_st inside {S_OP, S_ADDR, S_WDATA} && r_sh[SW-1]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op   <= '0;
      r_sub  <= '0;
      r_sh   <= '0;
      r_data <= '0;
      r_bit  <= '0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_op  <= cmd_op;
        r_sub <= cmd_addr[AW-1:AW-2];
        r_sh  <= {cmd_op, cmd_addr, cmd_data};
        r_err <= 1'b0;
      end else if (w_fall && r_st inside {S_OP, S_ADDR, S_WDATA}) r_sh <= r_sh << 1;
      else if (w_rise && r_st == S_RDATA && r_bit != '0) r_sh <= {r_sh[SW-2:0], sdo};
      if (r_st == S_POLL && w_nxt == S_DONE && !sdo) r_err <= 1'b1;
      if (r_st == S_RDATA && w_last) r_data <= r_sh[DW-1:0];
      r_bit <= w_last ? '0 : w_fall ? r_bit + 1'b1 : r_bit;
      r_tmo <= (r_st == w_nxt && r_st inside {S_GAP, S_POLL}) ? r_tmo + 1'b1 : '0;
    end
endmodule

// File: tb/tb_jt9346_ctrl.sv
// tb_jt9346_ctrl: directed bench for jt9346_ctrl against a behavioural 93C46-style EEPROM
module tb_jt9346_ctrl;
  import jt9346_pkg::*;
  localparam int AW = 6, DW = 16, DIV = 4, TOUT = 100, BUSY = 40, LIM = 5000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_err, sclk, sdi, scs, sdo;
  logic [DW-1:0] rsp_data;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  jt9346_ctrl #(.AW(AW), .DW(DW), .DIV(DIV), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .sclk(sclk), .sdi(sdi), .scs(scs), .sdo(sdo)
  );
  // EEPROM model: decodes on sclk rise, drives ready/busy on sdo while selected
  logic [15:0] mem [64];
  logic [23:0] m_sr = '0;
  logic [4:0] m_n = '0;
  logic [15:0] m_rdsr = '0;
  logic m_sclk_d = 1'b0, m_ewen = 1'b0, m_rd = 1'b0, m_do = 1'b0, m_stuck = 1'b0;
  int m_busy = 0;
  logic pl_we = 1'b0;
  logic [5:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [24:0] w_nsr;
  assign w_nsr = {m_sr, sdi};
  assign sdo = m_rd ? m_do : (scs && m_busy == 0 && !m_stuck);
  always @(posedge clk) begin
    m_sclk_d <= sclk;
    if (m_busy > 0) m_busy <= m_busy - 1;
    if (pl_we) mem[pl_addr] <= pl_data;
    if (!scs) begin
      m_n  <= '0;
      m_rd <= 1'b0;
    end else if (sclk && !m_sclk_d) begin
      if (m_rd) begin
        m_do   <= m_rdsr[15];
        m_rdsr <= {m_rdsr[14:0], 1'b0};
      end else if (m_n != 0 || sdi) begin
        m_sr <= w_nsr[23:0];
        m_n  <= m_n + 1'b1;
        if (m_n == 8) begin
          if (w_nsr[7:6] == OP_READ) begin m_rd <= 1'b1; m_do <= 1'b0; m_rdsr <= mem[w_nsr[5:0]]; end
          if (w_nsr[7:6] == OP_ERASE && m_ewen) begin mem[w_nsr[5:0]] <= '1; m_busy <= BUSY; end
          if (w_nsr[7:6] == OP_EXT && w_nsr[5:4] == EXT_EWEN) m_ewen <= 1'b1;
          if (w_nsr[7:6] == OP_EXT && w_nsr[5:4] == EXT_EWDS) m_ewen <= 1'b0;
          if (w_nsr[7:6] == OP_EXT && w_nsr[5:4] == EXT_ERAL && m_ewen) begin
            for (int i = 0; i < 64; i++) mem[i] <= '1;
            m_busy <= BUSY;
          end
        end
        if (m_n == 24 && m_ewen) begin
          if (w_nsr[23:22] == OP_WRITE) begin mem[w_nsr[21:16]] <= w_nsr[15:0]; m_busy <= BUSY; end
          if (w_nsr[23:22] == OP_EXT && w_nsr[21:20] == EXT_WRAL) begin
            for (int i = 0; i < 64; i++) mem[i] <= w_nsr[15:0];
            m_busy <= BUSY;
          end
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [15:0] data,
                        output logic [15:0] rd, output logic er, output int hi);
    int t;
    t = 0;
    while (!cmd_ready && t < LIM) begin @(negedge clk); t++; end
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    hi = 0;
    t = 0;
    while (!rsp_valid && t < LIM) begin hi += int'(scs); @(negedge clk); t++; end
    check("rsp_wait_expired", 32'(t >= LIM), 0);
    rd = rsp_data;
    er = rsp_err;
    @(negedge clk);
  endtask
  initial begin
    logic [15:0] rd;
    logic er, pend;
    logic [16:0] e;
    logic [16:0] q [$];
    int hi, n, act, k, n_acc, n_rsp;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdi", sdi, 0);
    check("rst_scs", scs, 0);
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin @(negedge clk); act += int'(scs | sclk | sdi); end
    check("post_rst_quiet", act, 0);
    do_cmd(OP_EXT, 6'h30, 16'h0, rd, er, hi);
    check("ewen_err", er, 0);
    do_cmd(OP_WRITE, 6'h05, 16'hA55A, rd, er, hi);
    check("wr05_err", er, 0);
    do_cmd(OP_READ, 6'h05, 16'h0, rd, er, hi);
    check("rd05_data", rd, 16'hA55A);
    check("rd05_err", er, 0);
    pl_addr = 6'h3F; pl_data = 16'h1234; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
    do_cmd(OP_READ, 6'h3F, 16'h0, rd, er, hi);
    check("rd3f_scs_cycles", hi, 208);
    check("rd3f_data", rd, 16'h1234);
    do_cmd(OP_WRITE, 6'h06, 16'hBEEF, rd, er, hi);
    check("wr_keeps_rsp_data", rd, 16'h1234);
    do_cmd(OP_EXT, 6'h00, 16'h0, rd, er, hi);
    do_cmd(OP_WRITE, 6'h05, 16'h1111, rd, er, hi);
    check("wr_locked_err", er, 0);
    do_cmd(OP_READ, 6'h05, 16'h0, rd, er, hi);
    check("rd_after_locked_wr", rd, 16'hA55A);
    do_cmd(OP_EXT, 6'h30, 16'h0, rd, er, hi);
    m_stuck = 1'b1;
    cmd_op = OP_ERASE; cmd_addr = 6'h10; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (scs && n < LIM) begin @(negedge clk); n++; end
    while (!scs && n < LIM) begin @(negedge clk); n++; end
    check("poll_entry_wait_expired", 32'(n >= LIM), 0);
    n = 0;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    check("poll_tout_cycles", n, TOUT);
    check("poll_tout_err", rsp_err, 1);
    @(negedge clk);
    m_stuck = 1'b0;
    do_cmd(OP_READ, 6'h10, 16'h0, rd, er, hi);
    check("rd_erased_data", rd, 16'hFFFF);
    check("err_cleared", er, 0);
    cmd_op = OP_READ; cmd_addr = 6'h05; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midaddr_rst_scs", scs, 0);
    check("midaddr_rst_ready", cmd_ready, 1);
    check("midaddr_rst_sclk", sclk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd(OP_READ, 6'h05, 16'h0, rd, er, hi);
    check("rd_after_rst", rd, 16'hA55A);
    k = 0; n_acc = 0; n_rsp = 0; pend = 1'b0;
    cmd_op = OP_WRITE; cmd_addr = 6'h20; cmd_data = 16'hC000; cmd_valid = 1'b1;
    for (int t = 0; t < 4 * LIM && n_rsp < 6; t++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        k++;
        if (k == 6) cmd_valid = 1'b0;
        else begin
          cmd_op   = k[0] ? OP_READ : OP_WRITE;
          cmd_addr = 6'(32'h20 + (k & ~1));
          cmd_data = 16'(32'hC000 + k);
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        e = q.size() != 0 ? q.pop_front() : 17'h0;
        if (e[16]) check("b2b_rd_data", rsp_data, e[15:0]);
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        pend = 1'b1;
        q.push_back({cmd_op == OP_READ, 16'(32'hC000 + k - 1)});
      end
    end
    repeat (50) begin
      @(negedge clk);
      n_rsp += int'(rsp_valid);
      n_acc += int'(cmd_valid && cmd_ready);
    end
    check("b2b_accepts", n_acc, 6);
    check("b2b_responses", n_rsp, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
